// File: rtl/ram_pkg.sv
// Shared types and helpers for the RAM round-robin arbiter.
package ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: first set request after ptr, wrapping.
module rr_priority_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    cand      = '0;
    any_req   = |req;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req[cand]) grant_idx = cand;
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin sequencer sharing one single-port RAM between NUM_REQ clients.
module ram_rr_arbiter
  import ram_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr_rd,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_dout,
  output logic                          ram_en,
  output logic                          ram_valid,
  output logic                          ram_wr_rd,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  input  logic                          ram_ready,
  input  logic                          ram_error
);

  localparam int IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
  localparam int CNT_W = clog2(TIMEOUT + 1);

  logic [ADDR_WIDTH-1:0] addr_slice [NUM_REQ];
  logic [DATA_WIDTH-1:0] din_slice  [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign addr_slice[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign din_slice[gi]  = req_din[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  state_t                state_reg, state_next;
  logic [IDX_W-1:0]      ptr_reg, ptr_next;
  logic [IDX_W-1:0]      idx_reg, idx_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next, cnt_inc;
  logic [IDX_W-1:0]      pick_idx;
  logic                  any_req;

  logic [NUM_REQ-1:0]    ack_next;
  logic                  rsp_err_next;
  logic [DATA_WIDTH-1:0] rsp_dout_next;
  logic                  ram_en_next, ram_valid_next, ram_wr_rd_next;
  logic [ADDR_WIDTH-1:0] ram_addr_next;
  logic [DATA_WIDTH-1:0] ram_din_next;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req),
    .ptr       (ptr_reg),
    .grant_idx (pick_idx),
    .any_req   (any_req)
  );

  assign cnt_inc = cnt_reg + CNT_W'(1);

  // Outputs are computed for the state being entered so they appear registered.
  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    idx_next       = idx_reg;
    cnt_next       = cnt_reg;
    ack_next       = '0;
    rsp_err_next   = 1'b0;
    rsp_dout_next  = '0;
    ram_en_next    = 1'b0;
    ram_valid_next = 1'b0;
    ram_wr_rd_next = ram_wr_rd;
    ram_addr_next  = ram_addr;
    ram_din_next   = ram_din;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next     = ISSUE;
          idx_next       = pick_idx;
          ptr_next       = pick_idx;
          ram_en_next    = 1'b1;
          ram_valid_next = 1'b1;
          ram_wr_rd_next = req_wr_rd[pick_idx];
          ram_addr_next  = addr_slice[pick_idx];
          ram_din_next   = din_slice[pick_idx];
        end
      end
      ISSUE: begin
        state_next = WAIT;
        cnt_next   = '0;
      end
      WAIT: begin
        if (ram_error) begin
          state_next   = RESP;
          ack_next     = NUM_REQ'(1) << idx_reg;
          rsp_err_next = 1'b1;
        end else if (ram_ready) begin
          state_next    = RESP;
          ack_next      = NUM_REQ'(1) << idx_reg;
          rsp_dout_next = ram_wr_rd ? '0 : ram_dout;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_next   = RESP;
            ack_next     = NUM_REQ'(1) << idx_reg;
            rsp_err_next = 1'b1;
          end
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      ptr_reg   <= IDX_W'(NUM_REQ - 1);
      idx_reg   <= '0;
      cnt_reg   <= '0;
      ack       <= '0;
      rsp_err   <= 1'b0;
      rsp_dout  <= '0;
      ram_en    <= 1'b0;
      ram_valid <= 1'b0;
      ram_wr_rd <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      ack       <= ack_next;
      rsp_err   <= rsp_err_next;
      rsp_dout  <= rsp_dout_next;
      ram_en    <= ram_en_next;
      ram_valid <= ram_valid_next;
      ram_wr_rd <= ram_wr_rd_next;
      ram_addr  <= ram_addr_next;
      ram_din   <= ram_din_next;
    end
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single_port_ram instance between NUM_REQ requesters.
- Each requester presents a one-word read or write request. The arbiter grants one request at a time, drives the RAM en/valid handshake, waits for ready/error, and returns a single-cycle ack with read data and error status.
- Sits between the requester clients and the RAM. The RAM ports connect one-to-one.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 5, RAM address width.
- DATA_WIDTH, 32, RAM data width.
- TIMEOUT, 8, maximum WAIT cycles without ready/error before the arbiter aborts.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- req  in  NUM_REQ  per-requester request; held high until that requester's ack.
- req_wr_rd  in  NUM_REQ  per-requester: 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- req_din  in  NUM_REQ*DATA_WIDTH  packed write data.
- ack  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_err  out  1  valid with ack; 1 = RAM error or timeout.
- rsp_dout  out  DATA_WIDTH  valid with ack; read data, 0 for writes and errors.
- ram_en, ram_valid, ram_wr_rd  out  1  RAM controls.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_dout  in  DATA_WIDTH  RAM read data.
- ram_ready, ram_error  in  1  RAM status.

Behaviour:
- All outputs are registered. On reset every output is 0, state = IDLE, round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, pick the first set bit searching from pointer+1 upward with wrap-around.
  - Latch that requester's index, wr_rd, addr and din.
  - Update pointer to the granted index and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - ram_en = ram_valid = 1; ram_wr_rd/addr/din = latched values.
  - Go to WAIT.
- WAIT:
  - ram_en = ram_valid = 0; ram_addr/din hold their values.
  - ram_error = 1 -> RESP with err = 1, dout = 0. ram_error takes priority if it occurs together with ram_ready.
  - Else ram_ready = 1 -> RESP with err = 0, dout = ram_dout for a read, 0 for a write.
  - Else increment the wait counter. When the counter reaches TIMEOUT, go to RESP with err = 1, dout = 0.
- RESP (1 cycle):
  - ack[idx] = 1, with rsp_err and rsp_dout valid.
  - No arbitration in this state, so a requester still holding req in the ack cycle is not re-granted.
  - Go to IDLE.
- Latency: req sampled high in IDLE at edge 0 -> ram_valid high in cycle 1 -> RAM ready visible in cycle 2 -> ack high in cycle 3. Peak rate is 1 transaction per 4 cycles.
- A requester must drop or update req in the cycle after its ack. Dropping req mid-transaction does not abort it; ack still pulses.
- Fairness: with requests continuously pending, grants rotate 0,1,...,NUM_REQ-1,0,...
- Width rules:
  - The wait counter is clog2(TIMEOUT+1) bits and is cleared on entry to WAIT.
  - The index register is clog2(NUM_REQ) bits, minimum 1.
- Reset mid-operation: immediately returns to reset values. No ack is issued for the in-flight transaction; a RAM write already sampled may have completed.

Decomposition:
- Shared package ram_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - default ADDR_WIDTH/DATA_WIDTH;
  - a clog2 helper function.
- One sub-module, rr_priority_pick: combinational round-robin selector taking the req vector and pointer, returning grant index and any_req.

Test Plan:
- Single write then read: req[0] write addr 3, din 0xDEADBEEF; then read addr 3 -> ack[0] high in cycle 3 each time; read rsp_dout = 0xDEADBEEF, rsp_err = 0.
- Contention: req[0] and req[1] both held high for 3 transactions each -> grant order 0,1,0,1,0,1; no requester is acked twice consecutively while the other is pending.
- RAM error: stub forces ram_error = 1 in WAIT on a read of addr 7 -> ack pulses, rsp_err = 1, rsp_dout = 0.
- Timeout: stub never asserts ready/error -> after 8 WAIT cycles, ack pulses with rsp_err = 1; the next request is served normally.
- Reset mid-transaction: rstn low during WAIT -> all outputs 0 asynchronously, no ack; after release, req[1] is served before req[0]? No — pointer resets, so req[0] has priority when both are pending.
- ram_valid pulse check: every grant produces exactly one cycle of ram_en = ram_valid = 1, with addr/din matching the granted requester's slice.
